// File: rtl/seg_display_arbiter.sv
// Shares a 4-digit multiplexed seven-segment display among three requesters:
// fixed-priority arbitration with a minimum hold, continuous digit scan, per-owner blink.
module seg_display_arbiter #(
    parameter int unsigned SCAN_DIV     = 500,
    parameter int unsigned HOLD_CYCLES  = 1000000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [31:0] frame0,
    input  logic [31:0] frame1,
    input  logic [31:0] frame2,
    input  logic [2:0]  blink,
    output logic [2:0]  grant,
    output logic [3:0]  anodes,
    output logic [7:0]  cathodes,
    output logic        frame_done
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned BF_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_FREE = 2'd2;

    // A fresh grant with a single-cycle hold is immediately preemptible.
    localparam logic [1:0]        S_LOAD    = (HOLD_CYCLES == 1) ? S_FREE : S_HOLD;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BF_W-1:0]   BF_LAST   = BF_W'(BLINK_FRAMES - 1);

    logic [1:0]        r_state;
    logic [2:0]        r_grant;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [1:0]        r_digit;
    logic              r_blink_phase;
    logic [BF_W-1:0]   r_blink_frame_cnt;
    logic [3:0]        r_anodes;
    logic [7:0]        r_cathodes;
    logic              r_frame_done;

    logic [1:0]        w_state_nxt;
    logic [2:0]        w_grant_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_owner_req;
    logic [2:0]        w_others;
    logic [2:0]        w_higher;
    logic              w_scan_last;
    logic              w_frame_end;
    logic [SCAN_W-1:0] w_scan_nxt;
    logic [1:0]        w_digit_nxt;
    logic [31:0]       w_owner_frame;
    logic              w_owner_blink;
    logic [7:0]        w_byte;
    logic [3:0]        w_anodes_nxt;
    logic [7:0]        w_cathodes_nxt;

    // Isolates the lowest set bit, i.e. the highest-priority request.
    function automatic logic [2:0] f_pick(input logic [2:0] v);
        return v & (~v + 3'd1);
    endfunction

    always_comb begin
        w_owner_req = |(req & r_grant);
        w_others    = req & ~r_grant;
        w_higher    = req & (r_grant - 3'd1);
    end

    // Arbiter next state: release is never gated, preemption waits for FREE.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_grant_nxt = f_pick(req);
                    w_hold_nxt  = HOLD_LOAD;
                    w_state_nxt = S_LOAD;
                end
            end
            S_HOLD, S_FREE: begin
                if (!w_owner_req) begin
                    if (|w_others) begin
                        w_grant_nxt = f_pick(w_others);
                        w_hold_nxt  = HOLD_LOAD;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_grant_nxt = 3'b000;
                        w_hold_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_state == S_HOLD) begin
                    w_hold_nxt = r_hold_cnt - HOLD_W'(1);
                    if (r_hold_cnt == HOLD_W'(1)) begin
                        w_state_nxt = S_FREE;
                    end
                end else if (|w_higher) begin
                    w_grant_nxt = f_pick(w_higher);
                    w_hold_nxt  = HOLD_LOAD;
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_grant_nxt = 3'b000;
                w_hold_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant    <= 3'b000;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Free-running digit scanner.
    always_comb begin
        w_scan_last = (r_scan_cnt == SCAN_LAST);
        w_frame_end = w_scan_last && (r_digit == 2'd3);
        w_scan_nxt  = w_scan_last ? '0 : r_scan_cnt + SCAN_W'(1);
        w_digit_nxt = w_scan_last ? r_digit + 2'd1 : r_digit;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scan_cnt        <= '0;
            r_digit           <= 2'd0;
            r_frame_done      <= 1'b0;
            r_blink_phase     <= 1'b0;
            r_blink_frame_cnt <= '0;
        end else begin
            r_scan_cnt   <= w_scan_nxt;
            r_digit      <= w_digit_nxt;
            // Registered from next-state values so the pulse lines up with the last dwell cycle.
            r_frame_done <= (w_scan_nxt == SCAN_LAST) && (w_digit_nxt == 2'd3);
            if (w_frame_end) begin
                if (r_blink_frame_cnt == BF_LAST) begin
                    r_blink_frame_cnt <= '0;
                    r_blink_phase     <= ~r_blink_phase;
                end else begin
                    r_blink_frame_cnt <= r_blink_frame_cnt + BF_W'(1);
                end
            end
        end
    end

    // Display drive from current digit and owner; frame bytes are taken live.
    always_comb begin
        case (r_grant)
            3'b001:  w_owner_frame = frame0;
            3'b010:  w_owner_frame = frame1;
            3'b100:  w_owner_frame = frame2;
            default: w_owner_frame = 32'hFFFF_FFFF;
        endcase
        w_owner_blink = |(blink & r_grant);
        case (r_digit)
            2'd0:    begin w_byte = w_owner_frame[7:0];   w_anodes_nxt = 4'b0111; end
            2'd1:    begin w_byte = w_owner_frame[15:8];  w_anodes_nxt = 4'b1011; end
            2'd2:    begin w_byte = w_owner_frame[23:16]; w_anodes_nxt = 4'b1101; end
            default: begin w_byte = w_owner_frame[31:24]; w_anodes_nxt = 4'b1110; end
        endcase
        w_cathodes_nxt = (w_owner_blink && r_blink_phase) ? 8'hFF : w_byte;
        if (r_grant == 3'b000) begin
            w_anodes_nxt   = 4'b1111;
            w_cathodes_nxt = 8'hFF;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_anodes   <= 4'b1111;
            r_cathodes <= 8'hFF;
        end else begin
            r_anodes   <= w_anodes_nxt;
            r_cathodes <= w_cathodes_nxt;
        end
    end

    assign grant      = r_grant;
    assign anodes     = r_anodes;
    assign cathodes   = r_cathodes;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomized and directed bench for seg_display_arbiter against a cycle-count based reference model.
module tb_seg_display_arbiter;

    localparam int unsigned S  = 4;
    localparam int unsigned H  = 8;
    localparam int unsigned BF = 2;
    localparam int unsigned FR = 4 * S;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [31:0] frame0, frame1, frame2;
    logic [2:0]  blink;
    logic [2:0]  grant;
    logic [3:0]  anodes;
    logic [7:0]  cathodes;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: edges since reset, owner index (-1 idle), edges owned so far.
    int nedges;
    int owner;
    int age;

    seg_display_arbiter #(.SCAN_DIV(S), .HOLD_CYCLES(H), .BLINK_FRAMES(BF)) dut (
        .clock(clock), .reset(reset), .req(req),
        .frame0(frame0), .frame1(frame1), .frame2(frame2), .blink(blink),
        .grant(grant), .anodes(anodes), .cathodes(cathodes), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [2:0] v);
        for (int i = 0; i < 3; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [2:0] onehot(input int idx);
        logic [2:0] v;
        v = 3'b000;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        nedges = 0;
        owner  = -1;
        age    = 0;
    endtask

    // One clock: predict outputs from model state and current inputs, then compare.
    task automatic tick();
        int d, ph;
        logic [31:0] fr;
        logic [3:0]  ea;
        logic [7:0]  ec;
        logic [2:0]  others;
        d  = int'((nedges % FR) / S);
        ph = int'(((nedges / FR) / BF) % 2);
        if (owner < 0) begin
            ea = 4'b1111;
            ec = 8'hFF;
        end else begin
            ea = ~(4'b1000 >> d);
            fr = (owner == 0) ? frame0 : (owner == 1) ? frame1 : frame2;
            ec = (blink[owner] && ph == 1) ? 8'hFF : fr[d*8 +: 8];
        end
        if (owner < 0) begin
            if (req != 3'b000) begin owner = lowest(req); age = 1; end
        end else if (!req[owner]) begin
            others = req;
            others[owner] = 1'b0;
            owner = lowest(others);
            age = 1;
        end else if (age >= H && lowest(req) < owner) begin
            owner = lowest(req);
            age = 1;
        end else if (age < H) begin
            age++;
        end
        @(posedge clock);
        #1;
        nedges++;
        check("grant",      32'(grant),      32'(onehot(owner)));
        check("anodes",     32'(anodes),     32'(ea));
        check("cathodes",   32'(cathodes),   32'(ec));
        check("frame_done", 32'(frame_done), 32'((nedges % FR) == FR - 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},    32'(grant),      32'h0);
        check({tag, "_anodes"},   32'(anodes),     32'hF);
        check({tag, "_cathodes"}, 32'(cathodes),   32'hFF);
        check({tag, "_fdone"},    32'(frame_done), 32'h0);
    endtask

    initial begin
        bit found;
        reset  = 1'b1;
        req    = 3'b000;
        frame0 = 32'h0;
        frame1 = 32'h0;
        frame2 = 32'h0;
        blink  = 3'b000;
        model_reset();
        #12;
        check_reset_outputs("rst");
        @(negedge clock);
        reset = 1'b0;

        // Idle scanning
        repeat (40) tick();

        // Single low-priority requester
        frame2 = 32'h99A4B0C0;
        req = 3'b100;
        repeat (20) tick();

        // Higher-priority request gated by hold
        req = 3'b000;
        tick();
        req = 3'b100;
        tick();
        tick();
        tick();
        req = 3'b101;
        frame0 = 32'h12345678;
        repeat (12) tick();

        // Owner keeps grant against lower-priority requests
        req = 3'b111;
        repeat (30) tick();

        // Release hands over without an idle cycle, then full release
        frame1 = 32'hA1B2C3D4;
        req = 3'b110;
        repeat (3) tick();
        req = 3'b000;
        repeat (3) tick();

        // Blink on owner 1, then blink disabled
        req = 3'b010;
        blink = 3'b010;
        repeat (80) tick();
        blink = 3'b000;
        repeat (40) tick();

        // Async reset mid-scan with grant 001 on digit 2
        req = 3'b001;
        blink = 3'b000;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            tick();
            if (owner == 0 && ((nedges % FR) / S) == 2) found = 1'b1;
        end
        check("seek_digit2", 32'(found), 32'h1);
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        repeat (20) tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) req = 3'($urandom);
            if ($urandom_range(0, 31) == 0) frame0 = $urandom;
            if ($urandom_range(0, 31) == 0) frame1 = $urandom;
            if ($urandom_range(0, 31) == 0) frame2 = $urandom;
            if ($urandom_range(0, 63) == 0) blink = 3'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
